nanocache_mem_resp: RTL and testbench
=====================================

Name: nanocache_mem_resp

Overview:
- Memory-side responder for the NanoCache line-refill/writeback request port. The cache side drives rden/wren, addr and wdata, and receives gnt, rdata and rvalid.
- Accepts one 8x32-bit line request at a time.
- Serialises the line into eight 32-bit beats on a single-port backing SRAM with 1-cycle read latency.
- Returns a read line as a single-cycle rvalid pulse with the full 256-bit line.

Parameters:
- MEM_AW, 14, backing SRAM word-address width. Line address field is i_mm_addr[MEM_AW+1:5].
- NUM_BEAT, 8, words per line; fixed, must equal 8. Package constant, not overridable in practice.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_mm_rden  in  1  line read request; held by requester until gnt
- i_mm_wren  in  1  line write request; held until gnt
- i_mm_addr  in  32  byte address; bits [4:0] ignored (line aligned)
- i_mm_wdata  in  [7:0][31:0]  write line; word k goes to beat k
- o_mm_gnt  out  1  request accepted this cycle (combinational)
- o_mm_rdata  out  [7:0][31:0]  read line; registered, holds until next rvalid
- o_mm_rvalid  out  1  one-cycle pulse, o_mm_rdata valid
- o_sram_en  out  1  backing SRAM access enable
- o_sram_we  out  1  backing SRAM write enable (qualified by en)
- o_sram_addr  out  MEM_AW  word address {line_addr, beat[2:0]}
- o_sram_wdata  out  32  write word
- i_sram_rdata  in  32  read word, valid the cycle after en & ~we
- o_busy  out  1  state != IDLE

Behaviour:
- Reset:
  - state=IDLE; beat counter=0.
  - o_mm_rvalid=0, o_mm_rdata=0, o_mm_gnt=0, o_sram_en=0, o_sram_we=0, o_sram_addr=0, o_sram_wdata=0, o_busy=0.
  - Reset mid-burst abandons the burst. No rvalid is produced. Partially written SRAM words stay written.
- States: IDLE, WR_BURST, RD_BURST, RD_WAIT.
- Acceptance: o_mm_gnt = (state==IDLE) & (i_mm_rden|i_mm_wren).
  - At gnt, the block latches the line address, the wdata line, and a pending-read flag (= i_mm_rden).
  - Requests outside IDLE are ignored; the requester keeps holding them.
- IDLE -> WR_BURST if wren. IDLE -> RD_BURST if rden only.
- WR_BURST, beats 0..7 over 8 cycles: en=1, we=1, addr={line,beat}, wdata=latched word[beat].
  - After beat 7: go to RD_BURST if the pending-read flag is set, else IDLE.
- rden & wren together means write-then-read-back: o_mm_rdata returns the newly written line.
- RD_BURST, beats 0..7: en=1, we=0, addr={line,beat}.
  - i_sram_rdata is captured into capture word[beat-1] one cycle after issue.
  - After beat 7: go to RD_WAIT.
- RD_WAIT (1 cycle): capture word 7. Register o_mm_rdata <= full line and o_mm_rvalid <= 1 for the next cycle. Go to IDLE.
- Latency, with gnt in cycle 0:
  - read only: beats issued in cycles 1-8, rvalid in cycle 10.
  - write only: writes in cycles 1-8, IDLE in cycle 9 (next gnt possible in cycle 9).
  - write+read: writes 1-8, reads 9-16, rvalid in cycle 18.
- A new gnt may coincide with the rvalid cycle (the state is already IDLE).
- Beat counter: 3 bits, wraps 7->0 at each burst end.
- o_sram_en=0 in IDLE. When en=0, o_sram_addr and o_sram_wdata are don't-care but driven 0.

Decomposition:
- Package nanocache_pkg: NUM_BEAT=8, typedef line_t ([7:0][31:0]), state enum mresp_state_e.
- No sub-module; single FSM with beat counter and capture register. The backing SRAM is external.

Test Plan:
- Reset, then idle with no request -> all outputs 0, o_busy=0, no o_sram_en for 20 cycles.
- Write 0x0000_0040 with words 0x1000+k, then read 0x0000_0040 -> write request gets gnt in the same cycle; 8 en&we beats at sram addr 0x10..0x17. Read returns rvalid exactly 10 cycles after its gnt with rdata[k]=0x1000+k.
- rden&wren together at 0x0000_0080, words 0xA5A5_0000+k -> one gnt; 8 writes then 8 reads at 0x20..0x27; rvalid 18 cycles after gnt with rdata[k]=0xA5A5_0000+k.
- Read held while busy; second read issued at cycle 3 -> no gnt until the rvalid cycle (cycle 10). Second gnt occurs in cycle 10, second rvalid in cycle 20.
- Address 0x0000_005F vs 0x0000_0040 -> identical sram addresses (low 5 bits ignored). Upper bits beyond MEM_AW+1 are ignored.
- Async reset asserted in RD_BURST cycle 4 -> no rvalid, o_busy=0 immediately. A fresh read after release completes normally with correct data.

Source files
------------

// File: rtl/nanocache_pkg.sv
// Shared types and constants for the NanoCache memory-side responder.
// A line is eight 32-bit words moved as eight SRAM beats.
package nanocache_pkg;

  localparam int NUM_BEAT = 8;
  localparam int BEAT_W   = 3;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEAT - 1);

  typedef logic [NUM_BEAT-1:0][31:0] line_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR_BURST,
    ST_RD_BURST,
    ST_RD_WAIT
  } mresp_state_e;

endpackage

// File: rtl/nanocache_mem_resp.sv
// Memory-side responder: accepts one line request at a time and serialises it
// into eight single-word beats on an external 1-cycle-latency SRAM.
module nanocache_mem_resp
  import nanocache_pkg::*;
#(
  parameter int MEM_AW = 14
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_mm_rden,
  input  logic              i_mm_wren,
  input  logic [31:0]       i_mm_addr,
  input  line_t             i_mm_wdata,
  output logic              o_mm_gnt,
  output line_t             o_mm_rdata,
  output logic              o_mm_rvalid,
  output logic              o_sram_en,
  output logic              o_sram_we,
  output logic [MEM_AW-1:0] o_sram_addr,
  output logic [31:0]       o_sram_wdata,
  input  logic [31:0]       i_sram_rdata,
  output logic              o_busy
);

  localparam int LINE_AW = MEM_AW - BEAT_W;

  mresp_state_e                r_state;
  mresp_state_e                w_nextState;
  logic [BEAT_W-1:0]           r_beat;
  logic [LINE_AW-1:0]          r_lineAddr;
  line_t                       r_wrLine;
  logic [NUM_BEAT-2:0][31:0]   r_capWords;
  logic                        r_pendRead;
  logic                        w_accept;
  logic                        w_lastBeat;
  logic                        w_unusedAddrBits;

  // Byte offset within the line and address bits above the SRAM are dropped.
  assign w_unusedAddrBits = ^{i_mm_addr[31:MEM_AW+2], i_mm_addr[4:0]};

  assign w_accept   = (r_state == ST_IDLE) && (i_mm_rden || i_mm_wren);
  assign w_lastBeat = (r_beat == LAST_BEAT);
  assign o_mm_gnt   = w_accept;
  assign o_busy     = (r_state != ST_IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // A combined read+write runs the write burst first so the read returns new data.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_mm_wren) begin
          w_nextState = ST_WR_BURST;
        end else if (i_mm_rden) begin
          w_nextState = ST_RD_BURST;
        end
      end
      ST_WR_BURST: begin
        if (w_lastBeat) begin
          w_nextState = r_pendRead ? ST_RD_BURST : ST_IDLE;
        end
      end
      ST_RD_BURST: begin
        if (w_lastBeat) begin
          w_nextState = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        w_nextState = ST_IDLE;
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_beat <= '0;
    end else if ((r_state == ST_WR_BURST) || (r_state == ST_RD_BURST)) begin
      r_beat <= r_beat + 1'b1;
    end else begin
      r_beat <= '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lineAddr <= '0;
      r_wrLine   <= '0;
      r_pendRead <= 1'b0;
    end else if (w_accept) begin
      r_lineAddr <= i_mm_addr[MEM_AW+1:5];
      r_wrLine   <= i_mm_wdata;
      r_pendRead <= i_mm_rden;
    end
  end

  // SRAM data lags the issued beat by one cycle; word 7 arrives in RD_WAIT.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_capWords <= '0;
    end else if ((r_state == ST_RD_BURST) && (r_beat != '0)) begin
      r_capWords[r_beat - 1'b1] <= i_sram_rdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_mm_rvalid <= 1'b0;
      o_mm_rdata  <= '0;
    end else begin
      o_mm_rvalid <= (r_state == ST_RD_WAIT);
      if (r_state == ST_RD_WAIT) begin
        o_mm_rdata <= {i_sram_rdata, r_capWords};
      end
    end
  end

  always_comb begin
    o_sram_en    = 1'b0;
    o_sram_we    = 1'b0;
    o_sram_addr  = '0;
    o_sram_wdata = '0;
    case (r_state)
      ST_WR_BURST: begin
        o_sram_en    = 1'b1;
        o_sram_we    = 1'b1;
        o_sram_addr  = {r_lineAddr, r_beat};
        o_sram_wdata = r_wrLine[r_beat];
      end
      ST_RD_BURST: begin
        o_sram_en   = 1'b1;
        o_sram_addr = {r_lineAddr, r_beat};
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_nanocache_mem_resp.sv
// Bench for nanocache_mem_resp: directed scenarios plus random line traffic,
// checked against a line-level memory model and the documented beat timeline.
module tb_nanocache_mem_resp;
  import nanocache_pkg::*;

  localparam int MEM_AW   = 14;
  localparam int LINE_CNT = 1 << (MEM_AW - 3);

  logic              i_clk = 1'b0;
  logic              i_rst_n;
  logic              i_mm_rden;
  logic              i_mm_wren;
  logic [31:0]       i_mm_addr;
  line_t             i_mm_wdata;
  logic              o_mm_gnt;
  line_t             o_mm_rdata;
  logic              o_mm_rvalid;
  logic              o_sram_en;
  logic              o_sram_we;
  logic [MEM_AW-1:0] o_sram_addr;
  logic [31:0]       o_sram_wdata;
  logic [31:0]       i_sram_rdata;
  logic              o_busy;

  int    vectors = 0;
  int    miscompares = 0;
  line_t lastLine = '0;
  line_t refMem [int];
  logic [31:0] sramMem [0:(1<<MEM_AW)-1];

  nanocache_mem_resp #(.MEM_AW(MEM_AW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_mm_rden(i_mm_rden), .i_mm_wren(i_mm_wren),
    .i_mm_addr(i_mm_addr), .i_mm_wdata(i_mm_wdata),
    .o_mm_gnt(o_mm_gnt), .o_mm_rdata(o_mm_rdata), .o_mm_rvalid(o_mm_rvalid),
    .o_sram_en(o_sram_en), .o_sram_we(o_sram_we), .o_sram_addr(o_sram_addr),
    .o_sram_wdata(o_sram_wdata), .i_sram_rdata(i_sram_rdata), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  // External backing SRAM with one cycle of read latency
  always @(posedge i_clk) begin
    if (o_sram_en) begin
      if (o_sram_we) sramMem[o_sram_addr] <= o_sram_wdata;
      else i_sram_rdata <= sramMem[o_sram_addr];
    end
  end

  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int lineOf(input logic [31:0] addr);
    return int'((addr >> 5) % LINE_CNT);
  endfunction

  function automatic line_t refRead(input int idx);
    if (refMem.exists(idx)) return refMem[idx];
    return '0;
  endfunction

  function automatic line_t randLine();
    line_t l;
    for (int k = 0; k < NUM_BEAT; k++) l[k] = $urandom;
    return l;
  endfunction

  function automatic line_t seqLine(input logic [31:0] base);
    line_t l;
    for (int k = 0; k < NUM_BEAT; k++) l[k] = base + 32'(k);
    return l;
  endfunction

  // Issues one request from IDLE and checks every cycle until it completes.
  task automatic applyStimulus(input bit rd, input bit wr, input logic [31:0] addr, input line_t wdata);
    int idx, waitCyc, base, total;
    line_t expLine;
    logic expEn, expWe, expRvalid;
    logic [MEM_AW-1:0] expAddr;
    logic [31:0] expWdata;
    idx = lineOf(addr);
    @(posedge i_clk); #1;
    i_mm_rden = rd; i_mm_wren = wr; i_mm_addr = addr; i_mm_wdata = wdata;
    @(negedge i_clk);
    waitCyc = 0;
    while (!o_mm_gnt && waitCyc < 40) begin
      @(negedge i_clk);
      waitCyc++;
    end
    checkOutput("gntSameCycle", 256'(waitCyc), 256'd0);
    if (!o_mm_gnt) begin
      i_mm_rden = 1'b0; i_mm_wren = 1'b0;
      return;
    end
    if (wr) refMem[idx] = wdata;
    expLine = refRead(idx);
    base  = wr ? NUM_BEAT : 0;
    total = rd ? base + NUM_BEAT + 2 : NUM_BEAT + 1;
    for (int c = 1; c <= total; c++) begin
      @(posedge i_clk); #1;
      i_mm_rden = 1'b0; i_mm_wren = 1'b0;
      i_mm_addr = $urandom; i_mm_wdata = randLine();
      @(negedge i_clk);
      expEn = 1'b0; expWe = 1'b0; expAddr = '0; expWdata = '0;
      if (wr && c <= NUM_BEAT) begin
        expEn = 1'b1; expWe = 1'b1;
        expAddr = MEM_AW'(idx * NUM_BEAT + c - 1);
        expWdata = wdata[c-1];
      end else if (rd && c > base && c <= base + NUM_BEAT) begin
        expEn = 1'b1;
        expAddr = MEM_AW'(idx * NUM_BEAT + c - base - 1);
      end
      expRvalid = rd && (c == total);
      checkOutput("sramEn", 256'(o_sram_en), 256'(expEn));
      checkOutput("sramWe", 256'(o_sram_we), 256'(expWe));
      checkOutput("sramAddr", 256'(o_sram_addr), 256'(expAddr));
      if (expWe || !expEn) checkOutput("sramWdata", 256'(o_sram_wdata), 256'(expWdata));
      checkOutput("busy", 256'(o_busy), 256'(c < total));
      checkOutput("rvalid", 256'(o_mm_rvalid), 256'(expRvalid));
      if (expRvalid) lastLine = expLine;
      checkOutput("rdata", 256'(o_mm_rdata), 256'(lastLine));
    end
  endtask

  // Second read raised in cycle 3 must wait for the first read's rvalid cycle.
  task automatic heldReadSequence(input logic [31:0] addrA, input logic [31:0] addrB);
    line_t lineA, lineB;
    lineA = refRead(lineOf(addrA));
    lineB = refRead(lineOf(addrB));
    @(posedge i_clk); #1;
    i_mm_rden = 1'b1; i_mm_wren = 1'b0; i_mm_addr = addrA;
    @(negedge i_clk);
    checkOutput("heldGnt0", 256'(o_mm_gnt), 256'd1);
    for (int c = 1; c <= 20; c++) begin
      @(posedge i_clk); #1;
      i_mm_rden = (c >= 3 && c <= 10);
      i_mm_addr = (c >= 3 && c <= 10) ? addrB : $urandom;
      @(negedge i_clk);
      checkOutput("heldGnt", 256'(o_mm_gnt), 256'(c == 10));
      checkOutput("heldRvalid", 256'(o_mm_rvalid), 256'(c == 10 || c == 20));
      if (c == 10) lastLine = lineA;
      if (c == 20) lastLine = lineB;
      checkOutput("heldRdata", 256'(o_mm_rdata), 256'(lastLine));
    end
    i_mm_rden = 1'b0;
  endtask

  // Async reset during the read burst abandons it; a fresh read then works.
  task automatic resetMidBurst(input logic [31:0] addr);
    @(posedge i_clk); #1;
    i_mm_rden = 1'b1; i_mm_addr = addr;
    @(negedge i_clk);
    checkOutput("rstGnt", 256'(o_mm_gnt), 256'd1);
    for (int c = 1; c <= 4; c++) begin
      @(posedge i_clk); #1;
      i_mm_rden = 1'b0;
      @(negedge i_clk);
    end
    checkOutput("rstBusyBefore", 256'(o_busy), 256'd1);
    #2 i_rst_n = 1'b0;
    #1;
    checkOutput("rstBusyNow", 256'(o_busy), 256'd0);
    checkOutput("rstSramEn", 256'(o_sram_en), 256'd0);
    checkOutput("rstRdata", 256'(o_mm_rdata), 256'd0);
    lastLine = '0;
    repeat (2) @(negedge i_clk);
    #2 i_rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge i_clk);
      checkOutput("rstNoRvalid", 256'(o_mm_rvalid), 256'd0);
      checkOutput("rstIdle", 256'(o_busy), 256'd0);
    end
    applyStimulus(1'b1, 1'b0, addr, '0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit rd, wr;
    for (int i = 0; i < (1 << MEM_AW); i++) sramMem[i] = '0;
    i_rst_n = 1'b0; i_mm_rden = 1'b0; i_mm_wren = 1'b0;
    i_mm_addr = '0; i_mm_wdata = '0;
    repeat (3) @(negedge i_clk);
    checkOutput("resetRvalid", 256'(o_mm_rvalid), 256'd0);
    checkOutput("resetRdata", 256'(o_mm_rdata), 256'd0);
    checkOutput("resetBusy", 256'(o_busy), 256'd0);
    checkOutput("resetSramAddr", 256'(o_sram_addr), 256'd0);
    #2 i_rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge i_clk);
      checkOutput("idleGnt", 256'(o_mm_gnt), 256'd0);
      checkOutput("idleSramEn", 256'(o_sram_en), 256'd0);
      checkOutput("idleSramWe", 256'(o_sram_we), 256'd0);
      checkOutput("idleSramWdata", 256'(o_sram_wdata), 256'd0);
      checkOutput("idleBusy", 256'(o_busy), 256'd0);
      checkOutput("idleRvalid", 256'(o_mm_rvalid), 256'd0);
    end

    applyStimulus(1'b0, 1'b1, 32'h0000_0040, seqLine(32'h0000_1000));
    applyStimulus(1'b1, 1'b0, 32'h0000_0040, '0);
    applyStimulus(1'b1, 1'b1, 32'h0000_0080, seqLine(32'hA5A5_0000));
    applyStimulus(1'b0, 1'b1, 32'h0000_0060, seqLine(32'h0000_3000));
    heldReadSequence(32'h0000_0040, 32'h0000_0060);
    applyStimulus(1'b1, 1'b0, 32'h0000_005F, '0);
    applyStimulus(1'b1, 1'b0, 32'hFFFF_0040, '0);
    applyStimulus(1'b0, 1'b1, 32'h0000_00A0, seqLine(32'h0BAD_0000));
    resetMidBurst(32'h0000_00A0);

    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 2))
        0: begin rd = 1'b1; wr = 1'b0; end
        1: begin rd = 1'b0; wr = 1'b1; end
        default: begin rd = 1'b1; wr = 1'b1; end
      endcase
      applyStimulus(rd, wr,
                    (32'($urandom_range(0, 65535)) << 16) |
                    (32'($urandom_range(0, 7)) << 5) |
                    32'($urandom_range(0, 31)),
                    randLine());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
